alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Registered issue/capture stage that wraps the combinational N-bit ALU (operand inputs A, B, 4-bit command CMD, result Z).
- Accepts one operation per valid/ready handshake and drives the ALU operand and command lines from registers.
- Waits a programmable settle time, captures Z into a result register and presents it downstream with a valid/ready handshake.
- Sits between the operand source (switch/register-file front end) and the result consumer (display/writeback).

Parameters:
- N, 6, operand/result width; must match the ALU's N.
- CMD_W, 4, ALU command width.
- SETTLE, 1, clock edges between driving the ALU lines and capturing Z; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_cmd  in  CMD_W  ALU command.
- alu_a  out  N  registered operand to ALU A.
- alu_b  out  N  registered operand to ALU B.
- alu_cmd  out  CMD_W  registered command to ALU CMD.
- alu_z  in  N  ALU result Z (combinational from alu_a/alu_b/alu_cmd).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_z  out  N  captured result.
- out_cmd  out  CMD_W  command that produced out_z.
- out_zero  out  1  out_z == 0; registered with out_z.
- op_count  out  8  completed-operation counter.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; alu_a, alu_b, alu_cmd, out_z, out_cmd, op_count = 0; out_valid=0; out_zero=0; settle counter=0. Reset mid-operation discards the operation; no partial result is emitted.
- FSM states: IDLE, SETTLE, RESULT; 2-bit encoding.
- in_ready = (state==IDLE); combinational from state only.
- IDLE: on an edge with in_valid=1, register alu_a<=in_a, alu_b<=in_b, alu_cmd<=in_cmd, cnt<=SETTLE-1, go to SETTLE. Without in_valid, all registers hold; alu_* keep their last values and are not cleared.
- SETTLE: each edge with cnt!=0 decrements cnt. The edge with cnt==0 captures out_z<=alu_z, out_cmd<=alu_cmd, out_zero<=(alu_z==0), sets out_valid<=1 and goes to RESULT.
- Latency: out_valid is high exactly SETTLE edges after the accepting edge (SETTLE=1 gives the result visible the cycle after issue).
- RESULT: out_valid, out_z, out_cmd and out_zero are held stable until out_ready=1.
  - On the edge with out_ready=1: out_valid<=0, op_count<=op_count+1 (wraps 255->0), go to IDLE.
  - in_valid during RESULT is ignored because in_ready=0; there is no same-cycle bypass, so the next accept is earliest one cycle after leaving RESULT. Throughput is one operation per SETTLE+2 cycles minimum.
- alu_* remain stable throughout SETTLE and RESULT. Upstream changes to in_* after acceptance have no effect.
- out_ready while not in RESULT is ignored.
- Width rule: no width extension; out_z is exactly alu_z[N-1:0].

Decomposition:
- Shared package alu_defs: CMD_W, state encodings (ST_IDLE, ST_SETTLE, ST_RESULT), default N.
- One natural sub-module: settle_timer (load value, decrement, zero flag, 4-bit).
- The ALU itself is not instantiated here; the top level wires alu_* and alu_z to K_ALU.

Test Plan:
- Bench ALU stub is alu_z = (alu_a+alu_b) mod 2^N, N=6.
- Reset then idle: rst pulse -> all outputs 0, in_ready=1, op_count=0; in_valid=0 for 10 cycles -> no state change.
- Single op, SETTLE=1: in_a=5, in_b=3, in_cmd=0, in_valid one cycle, out_ready=1 -> out_valid high for exactly one cycle one edge after accept; out_z=8, out_cmd=0, out_zero=0, op_count=1.
- Wrap and zero flag: in_a=60, in_b=4 -> out_z=0, out_zero=1; in_a=60, in_b=10 -> out_z=6.
- Backpressure, SETTLE=3: out_ready=0 for 5 cycles -> out_valid and out_z held, in_ready=0, a second in_valid is ignored; out_ready=1 -> one completion, op_count increments by exactly 1.
- Reset mid-SETTLE: assert rst during SETTLE -> out_valid never rises, all outputs 0 immediately (asynchronous); the next op completes normally.
- Counter wrap: 256 back-to-back ops -> op_count returns to 0.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// alu_defs: shared ALU width defaults and sequencer state encodings
package alu_defs;
  localparam int N_DEF = 6;
  localparam int CMD_W = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
endpackage

// File: rtl/alu_op_sequencer_settle_timer.sv
// settle_timer: 4-bit down-counter; load has priority, dec stops at zero, zero flags cnt==0
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one op to an external ALU (in_* -> alu_*), waits SETTLE edges, captures alu_z into out_* with valid/ready handshakes and counts completions in op_count
module alu_op_sequencer #(
  parameter int N = alu_defs::N_DEF,
  parameter int CMD_W = alu_defs::CMD_W,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [CMD_W-1:0] in_cmd,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [CMD_W-1:0] alu_cmd,
  input  logic [N-1:0]     alu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_z,
  output logic [CMD_W-1:0] out_cmd,
  output logic             out_zero,
  output logic [7:0]       op_count
);
  import alu_defs::*;
  logic [1:0] state;
  logic accept, settled;
  assign in_ready = state == ST_IDLE;
  assign accept = in_ready && in_valid;
  settle_timer u_timer (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .dec(state == ST_SETTLE),
    .load_val(4'(SETTLE - 1)),
    .zero(settled)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_cmd <= '0;
      out_z <= '0;
      out_cmd <= '0;
      out_zero <= 1'b0;
      out_valid <= 1'b0;
      op_count <= '0;
    end else if (accept) begin
      alu_a <= in_a;
      alu_b <= in_b;
      alu_cmd <= in_cmd;
      state <= ST_SETTLE;
    end else if (state == ST_SETTLE && settled) begin
      out_z <= alu_z;
      out_cmd <= alu_cmd;
      out_zero <= alu_z == '0;
      out_valid <= 1'b1;
      state <= ST_RESULT;
    end else if (state == ST_RESULT && out_ready) begin
      out_valid <= 1'b0;
      op_count <= op_count + 8'd1;
      state <= ST_IDLE;
    end
endmodule
